pwm_sequencer: RTL

PWM_SEQUENCER -- requirements
Module: pwm_sequencer

---
 rtl/pwm_sequencer.sv | 268 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pwm_sequencer.sv
// pwm_sequencer: walks a duty/pulse-count step table, programming a PWM controller
// over APB for each step and polling its enable bit until the step's pulses are done.
module pwm_sequencer #(
    parameter int unsigned NUM_STEPS      = 8,
    parameter int unsigned POLL_GAP       = 16,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000,
    localparam int unsigned AW = $clog2(NUM_STEPS),
    localparam int unsigned CW = AW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          tbl_we_i,
    input  logic [AW-1:0] tbl_addr_i,
    input  logic [23:0]   tbl_wdata_i,
    input  logic          start_i,
    input  logic          abort_i,
    input  logic          loop_i,
    input  logic [CW-1:0] num_steps_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o,
    output logic [AW-1:0] step_idx_o,
    output logic          psel_o,
    output logic          penable_o,
    output logic          pwrite_o,
    output logic [5:0]    paddr_o,
    output logic [31:0]   pwdata_o,
    input  logic [31:0]   prdata_i,
    input  logic          pready_i,
    input  logic          pslverr_i
);

    localparam int unsigned GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

    localparam logic [5:0] A_CTRL = 6'h00;
    localparam logic [5:0] A_DUTY = 6'h04;
    localparam logic [5:0] A_CNT  = 6'h08;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_WR_DUTY, S_WR_CNT, S_WR_EN,
        S_GAP, S_POLL, S_NEXT, S_STOP, S_FIN
    } state_t;

    state_t        r_state;
    logic [23:0]   r_tbl [NUM_STEPS];
    logic [CW-1:0] r_num;
    logic [AW-1:0] r_idx;
    logic [7:0]    r_duty;
    logic [15:0]   r_cnt;
    logic [23:0]   r_tmo;
    logic [GW-1:0] r_gap;
    logic          r_stop_req;
    logic          r_busy;
    logic          r_done;
    logic          r_err;
    logic          r_psel;
    logic          r_penable;
    logic          r_pwrite;
    logic [5:0]    r_paddr;
    logic [31:0]   r_pwdata;

    logic [23:0]   w_entry;
    logic [CW-1:0] w_idx_inc;
    logic [CW-1:0] w_num_clamped;
    logic          w_run;
    logic          w_in_wait;
    logic          w_tmo_now;
    logic          w_stop;
    logic          w_xfer_done;
    logic          w_is_xfer;
    logic          w_write;
    logic [5:0]    w_addr;
    logic [31:0]   w_wdata;
    logic          w_unused;

    assign w_entry       = r_tbl[r_idx];
    assign w_idx_inc     = {1'b0, r_idx} + CW'(1);
    assign w_num_clamped = (num_steps_i > CW'(NUM_STEPS)) ? CW'(NUM_STEPS) : num_steps_i;
    assign w_run         = (r_state != S_IDLE) && (r_state != S_STOP) && (r_state != S_FIN);
    assign w_in_wait     = (r_state == S_GAP) || (r_state == S_POLL);
    assign w_tmo_now     = w_in_wait && (r_tmo >= (TIMEOUT_CYCLES - 24'd1));
    // Abort, timeout and a latched earlier request all funnel into one stop condition.
    assign w_stop        = w_run && (r_stop_req || abort_i || w_tmo_now);
    assign w_xfer_done   = r_psel && r_penable && pready_i;
    assign w_unused      = ^prdata_i[31:1];

    // Transfer descriptor for the state's APB access.
    always_comb begin
        w_is_xfer = 1'b0;
        w_write   = 1'b0;
        w_addr    = 6'h00;
        w_wdata   = 32'h0;
        case (r_state)
            S_WR_DUTY: begin w_is_xfer = 1'b1; w_write = 1'b1; w_addr = A_DUTY; w_wdata = {24'd0, r_duty}; end
            S_WR_CNT:  begin w_is_xfer = 1'b1; w_write = 1'b1; w_addr = A_CNT;  w_wdata = {16'd0, r_cnt}; end
            S_WR_EN:   begin w_is_xfer = 1'b1; w_write = 1'b1; w_addr = A_CTRL; w_wdata = 32'h1; end
            S_POLL:    begin w_is_xfer = 1'b1; w_addr = A_CTRL; end
            S_STOP:    begin w_is_xfer = 1'b1; w_write = 1'b1; w_addr = A_CTRL; end
            default:   ;
        endcase
    end

    // Step table has no reset; writes are accepted at any time.
    always_ff @(posedge clk_i) begin
        if (tbl_we_i) r_tbl[tbl_addr_i] <= tbl_wdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_num      <= '0;
            r_idx      <= '0;
            r_duty     <= '0;
            r_cnt      <= '0;
            r_tmo      <= '0;
            r_gap      <= '0;
            r_stop_req <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_psel     <= 1'b0;
            r_penable  <= 1'b0;
            r_pwrite   <= 1'b0;
            r_paddr    <= '0;
            r_pwdata   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_tmo_now) r_err <= 1'b1;
            if (w_in_wait && (r_tmo != '1)) r_tmo <= r_tmo + 24'd1;
            if (w_stop && r_psel && !w_xfer_done) r_stop_req <= 1'b1;

            // APB phases: an idle cycle, setup, then access until pready.
            if (w_is_xfer) begin
                if (!r_psel) begin
                    if (!w_stop) begin
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_pwrite  <= w_write;
                        r_paddr   <= w_addr;
                        r_pwdata  <= w_wdata;
                    end
                end else if (!r_penable) begin
                    r_penable <= 1'b1;
                end else if (pready_i) begin
                    r_psel    <= 1'b0;
                    r_penable <= 1'b0;
                    r_pwrite  <= 1'b0;
                    r_paddr   <= '0;
                    r_pwdata  <= '0;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_busy <= 1'b1;
                        if (num_steps_i == '0) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_num   <= w_num_clamped;
                            r_err   <= 1'b0;
                            r_idx   <= '0;
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (w_stop) begin
                        r_state    <= S_STOP;
                        r_stop_req <= 1'b0;
                    end else if ((w_entry[7:0] == 8'd0) || (w_entry[23:8] == 16'd0)) begin
                        r_state <= S_NEXT;
                    end else begin
                        r_duty  <= w_entry[7:0];
                        r_cnt   <= w_entry[23:8];
                        r_state <= S_WR_DUTY;
                    end
                end
                S_WR_DUTY, S_WR_CNT, S_WR_EN, S_POLL: begin
                    if (!r_psel) begin
                        if (w_stop) begin
                            r_state    <= S_STOP;
                            r_stop_req <= 1'b0;
                        end
                    end else if (w_xfer_done) begin
                        if (pslverr_i) begin
                            r_err      <= 1'b1;
                            r_state    <= S_STOP;
                            r_stop_req <= 1'b0;
                        end else if (w_stop) begin
                            r_state    <= S_STOP;
                            r_stop_req <= 1'b0;
                        end else begin
                            case (r_state)
                                S_WR_DUTY: r_state <= S_WR_CNT;
                                S_WR_CNT:  r_state <= S_WR_EN;
                                S_WR_EN: begin
                                    r_tmo   <= '0;
                                    r_gap   <= '0;
                                    r_state <= S_GAP;
                                end
                                S_POLL: begin
                                    if (prdata_i[0]) begin
                                        r_gap   <= '0;
                                        r_state <= S_GAP;
                                    end else begin
                                        r_state <= S_NEXT;
                                    end
                                end
                                default: r_state <= S_IDLE;
                            endcase
                        end
                    end
                end
                S_GAP: begin
                    if (w_stop) begin
                        r_state    <= S_STOP;
                        r_stop_req <= 1'b0;
                    end else if (r_gap == GW'(POLL_GAP - 1)) begin
                        r_gap   <= '0;
                        r_state <= S_POLL;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                S_NEXT: begin
                    if (w_stop) begin
                        r_state    <= S_STOP;
                        r_stop_req <= 1'b0;
                    end else if (w_idx_inc < r_num) begin
                        r_idx   <= r_idx + AW'(1);
                        r_state <= S_FETCH;
                    end else if (loop_i) begin
                        r_idx   <= '0;
                        r_state <= S_FETCH;
                    end else begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                    end
                end
                S_STOP: begin
                    // Error response on the disabling write is deliberately ignored.
                    if (w_xfer_done) begin
                        r_state <= S_FIN;
                        r_done  <= 1'b1;
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign step_idx_o = r_idx;
    assign psel_o     = r_psel;
    assign penable_o  = r_penable;
    assign pwrite_o   = r_pwrite;
    assign paddr_o    = r_paddr;
    assign pwdata_o   = r_pwdata;

endmodule
